fxp_sqrt_unit: RTL and testbench

//   Iterative fixed-point square-root unit. It is the sqrt engine driven by the vector-normalisation

---
 rtl/fxp_sqrt_unit_if.sv | 22 ++
 rtl/fxp_sqrt_unit.sv | 109 ++++++++++
 tb/tb_fxp_sqrt_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fxp_sqrt_unit_if.sv
// Start/result handshake between the normalisation control unit and the sqrt engine.
// The master drives start/radicand; the slave returns root and status.
interface fxp_sqrt_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] radicand;
  logic [WIDTH-1:0] root;
  logic             ready;
  logic             busy;
  logic             neg_err;

  modport master (
    output start, radicand,
    input  root, ready, busy, neg_err
  );

  modport slave (
    input  start, radicand,
    output root, ready, busy, neg_err
  );
endinterface

// File: rtl/fxp_sqrt_unit.sv
// Iterative fixed-point square root: one root bit per clock, digit-by-digit method.
// Computes isqrt(radicand << FRAC), i.e. floor(sqrt(x)) in the radicand's Q format.
module fxp_sqrt_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 16,
  parameter bit          SIGNED = 1'b1
) (
  input logic            clock,
  input logic            reset,
  fxp_sqrt_unit_if.slave bus
);

  localparam int unsigned OpW  = WIDTH + FRAC;
  localparam int unsigned N    = OpW / 2;
  localparam int unsigned RemW = N + 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if ((OpW % 2) != 0 || FRAC > WIDTH) begin : g_bad_params
    $error("fxp_sqrt_unit: WIDTH+FRAC must be even and FRAC <= WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StErr, StDone} state_e;

  state_e            state_q;
  logic [OpW-1:0]    opnd_q;
  logic [RemW-1:0]   rem_q;
  logic [N-1:0]      q_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  root_q;
  logic              ready_q;
  logic              busy_q;
  logic              neg_err_q;

  logic [RemW+1:0]   dividend;
  logic [RemW+1:0]   subtrahend;
  logic              fits;
  logic [RemW-1:0]   rem_d;
  logic [N-1:0]      q_d;

  // Wide compare keeps the sign test exact on the last iteration; the
  // surviving remainder always fits in RemW bits.
  always_comb begin
    dividend   = {rem_q, opnd_q[OpW-1 -: 2]};
    subtrahend = {2'b00, q_q, 2'b01};
    fits       = (dividend >= subtrahend);
    rem_d      = fits ? RemW'(dividend - subtrahend) : RemW'(dividend);
    q_d        = N'({q_q, fits});
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      opnd_q    <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      root_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      neg_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            opnd_q    <= OpW'(bus.radicand) << FRAC;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= CntW'(N - 1);
            ready_q   <= 1'b0;
            neg_err_q <= 1'b0;
            busy_q    <= 1'b1;
            if (SIGNED && bus.radicand[WIDTH-1]) begin
              state_q <= StErr;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          opnd_q <= opnd_q << 2;
          rem_q  <= rem_d;
          q_q    <= q_d;
          if (cnt_q == '0) begin
            state_q <= StDone;
            root_q  <= WIDTH'(q_d);
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StErr: begin
          state_q   <= StDone;
          root_q    <= '0;
          neg_err_q <= 1'b1;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.root    = root_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.neg_err = neg_err_q;

endmodule

// File: tb/tb_fxp_sqrt_unit.sv
// Scoreboard bench for fxp_sqrt_unit: a signed and an unsigned instance share clock/reset;
// stimulus pushes expected results, a negedge monitor pops them when ready rises.
module tb_fxp_sqrt_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned F   = 16;
  localparam int          LAT = 24;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fxp_sqrt_unit_if #(.WIDTH(W)) bus_s ();
  fxp_sqrt_unit_if #(.WIDTH(W)) bus_u ();

  fxp_sqrt_unit #(.WIDTH(W), .FRAC(F), .SIGNED(1'b1)) u_dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  fxp_sqrt_unit #(.WIDTH(W), .FRAC(F), .SIGNED(1'b0)) u_dut_u (
    .clock (clock),
    .reset (reset),
    .bus   (bus_u.slave)
  );

  typedef struct {
    logic [31:0] rad;
    logic [31:0] root;
    logic        neg;
    int          due;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic mon_pop(input bit u);
    exp_t        e;
    logic [31:0] r;
    logic        n;
    if ((u ? q_u.size() : q_s.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready[%0d]: got ready=1, expected no result pending", u);
      return;
    end
    if (u) begin
      e = q_u.pop_front();
      r = bus_u.root;
      n = bus_u.neg_err;
    end else begin
      e = q_s.pop_front();
      r = bus_s.root;
      n = bus_s.neg_err;
    end
    check($sformatf("root[%0d] rad=%h", u, e.rad), r, e.root);
    check($sformatf("neg_err[%0d] rad=%h", u, e.rad), 32'(n), 32'(e.neg));
    check($sformatf("latency[%0d] rad=%h", u, e.rad), 32'(cycle), 32'(e.due));
  endtask

  logic prev_s = 1'b0;
  logic prev_u = 1'b0;
  always @(negedge clock) begin
    if (bus_s.ready && !prev_s) mon_pop(1'b0);
    if (bus_u.ready && !prev_u) mon_pop(1'b1);
    prev_s <= bus_s.ready;
    prev_u <= bus_u.ready;
  end

  // Call at a negedge; start is held across exactly one rising edge.
  task automatic start_op(input bit u, input logic [31:0] v, input logic [31:0] r,
                          input bit neg, input bit acc, input int lat);
    exp_t e;
    e.rad  = v;
    e.root = r;
    e.neg  = neg;
    e.due  = cycle + 1 + lat;
    if (u) begin
      bus_u.start    = 1'b1;
      bus_u.radicand = v;
      if (acc) q_u.push_back(e);
    end else begin
      bus_s.start    = 1'b1;
      bus_s.radicand = v;
      if (acc) q_s.push_back(e);
    end
    @(negedge clock);
    bus_s.start    = 1'b0;
    bus_u.start    = 1'b0;
    bus_s.radicand = $urandom;
    bus_u.radicand = $urandom;
    if (acc) check($sformatf("ready_low_after_start[%0d]", u),
                   32'(u ? bus_u.ready : bus_s.ready), 32'd0);
    check($sformatf("busy_after_start[%0d]", u), 32'(u ? bus_u.busy : bus_s.busy), 32'd1);
  endtask

  task automatic wait_done(input bit u);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if ((u ? q_u.size() : q_s.size()) == 0) break;
    end
    checks++;
    if ((u ? q_u.size() : q_s.size()) != 0) begin
      errors++;
      $display("FAIL timeout[%0d]: got %0d results pending, expected 0", u,
               u ? q_u.size() : q_s.size());
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus_s.ready), 32'd0);
    check({tag, "_busy"}, 32'(bus_s.busy), 32'd0);
    check({tag, "_root"}, bus_s.root, 32'd0);
    check({tag, "_neg_err"}, 32'(bus_s.neg_err), 32'd0);
  endtask

  logic [31:0] seq_rad  [3] = '{32'h0009_0000, 32'h0019_0000, 32'h0000_4000};
  logic [31:0] seq_root [3] = '{32'h0003_0000, 32'h0005_0000, 32'h0000_8000};

  initial begin
    bus_s.start = 1'b0;  bus_s.radicand = '0;
    bus_u.start = 1'b0;  bus_u.radicand = '0;
    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    // Basic: 4.0 -> 2.0 with fixed latency.
    start_op(1'b0, 32'h0004_0000, 32'h0002_0000, 1'b0, 1'b1, LAT);
    wait_done(1'b0);
    repeat (2) @(negedge clock);

    // Non-square, max positive, zero, one, smallest nonzero.
    start_op(1'b0, 32'h0002_0000, 32'h0001_6A09, 1'b0, 1'b1, LAT); wait_done(1'b0);
    start_op(1'b0, 32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0, 1'b1, LAT); wait_done(1'b0);
    start_op(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, LAT); wait_done(1'b0);
    start_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, LAT); wait_done(1'b0);
    start_op(1'b0, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b1, LAT); wait_done(1'b0);

    // Control-unit pattern: start 2 cycles after ready, ready must drop each time.
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clock);
      start_op(1'b0, seq_rad[i], seq_root[i], 1'b0, 1'b1, LAT);
      wait_done(1'b0);
    end

    // Start during CALC ignored; start on first DONE cycle accepted back-to-back.
    repeat (2) @(negedge clock);
    start_op(1'b0, 32'h0064_0000, 32'h000A_0000, 1'b0, 1'b1, LAT);
    repeat (4) @(negedge clock);
    start_op(1'b0, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, LAT);
    repeat (19) @(negedge clock);
    start_op(1'b0, 32'h00C4_0000, 32'h000E_0000, 1'b0, 1'b1, LAT);
    wait_done(1'b0);

    // Asynchronous reset mid-operation.
    repeat (2) @(negedge clock);
    start_op(1'b0, 32'h0004_0000, 32'h0002_0000, 1'b0, 1'b1, LAT);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    q_s.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start_op(1'b0, 32'h0009_0000, 32'h0003_0000, 1'b0, 1'b1, LAT);
    wait_done(1'b0);

    // Negative radicand: signed errors out in 2 edges, unsigned treats it as a magnitude.
    repeat (2) @(negedge clock);
    start_op(1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1);
    wait_done(1'b0);
    check("busy_after_err", 32'(bus_s.busy), 32'd0);
    start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1);
    wait_done(1'b0);
    start_op(1'b0, 32'h0010_0000, 32'h0004_0000, 1'b0, 1'b1, LAT);
    wait_done(1'b0);
    start_op(1'b1, 32'h8000_0000, 32'h00B5_04F3, 1'b0, 1'b1, LAT);
    wait_done(1'b1);
    start_op(1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF, 1'b0, 1'b1, LAT);
    wait_done(1'b1);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
